// File: rtl/mutex_rr_arb.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module   : mutex_rr_arb                                                  |
// | Purpose  : N-way round-robin mutex with a four-phase req/gnt handshake,  |
// |            registered one-hot grants and a guaranteed dead gap between   |
// |            successive owners.                                            |
// | Options  : define MUTEX_HOLD_TIMEOUT_EN to add the hold-time limit with  |
// |            forced revoke, timeout pulse and revoked-master masking.      |
// | Revision : 1.0  initial release                                          |
// +--------------------------------------------------------------------------+
module mutex_rr_arb #(
  parameter int N        = 4,
  parameter int OWN_W    = 2,
  parameter int GAP_CYC  = 1,
  parameter int HOLD_W   = 8,
  parameter int MAX_HOLD = 200
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [N-1:0]     req,
  output logic [N-1:0]     gnt,
  output logic             busy,
  output logic [OWN_W-1:0] owner,
  output logic             timeout
);

  // Reject illegal configurations at elaboration time.
  generate
    if (N < 2 || N > 16 || (1 << OWN_W) < N || GAP_CYC < 1 || GAP_CYC > 7 ||
        MAX_HOLD < 1 || MAX_HOLD >= (1 << HOLD_W)) begin : g_param_err
      $error("mutex_rr_arb: illegal parameter set");
    end
  endgenerate

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_GRANT = 2'd1,
    ST_GAP   = 2'd2
  } state_t;

  localparam logic [2:0]       C_GAP_LOAD = 3'(GAP_CYC);
  localparam logic [OWN_W-1:0] C_LAST_IDX = OWN_W'(N - 1);
  localparam logic [N-1:0]     C_ONE      = N'(1);

  state_t           state_q, state_d;
  logic [N-1:0]     gnt_q, gnt_d;
  logic [OWN_W-1:0] owner_q, owner_d;
  logic [OWN_W-1:0] ptr_q, ptr_d;
  logic [2:0]       gap_q, gap_d;

  logic [N-1:0]     req_elig;
  logic             hi_vld, lo_vld, pick_vld;
  logic [OWN_W-1:0] hi_idx, lo_idx, pick_idx;
  logic [OWN_W-1:0] owner_nxt;
  logic             owner_rel;

`ifdef MUTEX_HOLD_TIMEOUT_EN
  localparam logic [HOLD_W-1:0] C_MAX_HOLD = HOLD_W'(MAX_HOLD);

  logic [HOLD_W-1:0] hold_q, hold_d;
  logic [N-1:0]      mask_q, mask_d;
  logic              timeout_q, timeout_d;

  // A revoked master stays out of arbitration until it drops its request.
  assign req_elig = req & ~mask_q;
  assign timeout  = timeout_q;
`else
  assign req_elig = req;
  assign timeout  = 1'b0;
`endif

  // The owner releases when its own request bit is seen low; gnt_q is
  // one-hot on the owner while granted, so no index decode is needed.
  assign owner_rel = ~|(req & gnt_q);
  assign owner_nxt = (owner_q == C_LAST_IDX) ? '0 : owner_q + OWN_W'(1);

  // Round-robin pick: lowest eligible index at or above the pointer,
  // otherwise wrap around to the lowest eligible index below it.
  always_comb begin
    hi_vld = 1'b0;
    lo_vld = 1'b0;
    hi_idx = '0;
    lo_idx = '0;
    for (int i = N - 1; i >= 0; i--) begin
      if (req_elig[i]) begin
        if (OWN_W'(i) >= ptr_q) begin
          hi_vld = 1'b1;
          hi_idx = OWN_W'(i);
        end else begin
          lo_vld = 1'b1;
          lo_idx = OWN_W'(i);
        end
      end
    end
    pick_vld = hi_vld | lo_vld;
    pick_idx = hi_vld ? hi_idx : lo_idx;
  end

  // Next-state and next-output computation for the IDLE/GRANT/GAP machine.
  always_comb begin
    state_d = state_q;
    gnt_d   = gnt_q;
    owner_d = owner_q;
    ptr_d   = ptr_q;
    gap_d   = gap_q;
`ifdef MUTEX_HOLD_TIMEOUT_EN
    hold_d    = hold_q;
    mask_d    = mask_q & req;
    timeout_d = 1'b0;
`endif
    case (state_q)
      ST_IDLE: begin
        if (pick_vld) begin
          gnt_d   = C_ONE << pick_idx;
          owner_d = pick_idx;
          state_d = ST_GRANT;
`ifdef MUTEX_HOLD_TIMEOUT_EN
          hold_d  = HOLD_W'(1);
`endif
        end
      end
      ST_GRANT: begin
        if (owner_rel) begin
          gnt_d   = '0;
          ptr_d   = owner_nxt;
          gap_d   = C_GAP_LOAD;
          state_d = ST_GAP;
        end
`ifdef MUTEX_HOLD_TIMEOUT_EN
        else if (hold_q == C_MAX_HOLD) begin
          gnt_d     = '0;
          ptr_d     = owner_nxt;
          gap_d     = C_GAP_LOAD;
          state_d   = ST_GAP;
          timeout_d = 1'b1;
          mask_d    = (mask_q & req) | gnt_q;
        end else begin
          hold_d = hold_q + HOLD_W'(1);
        end
`endif
      end
      ST_GAP: begin
        gap_d = gap_q - 3'd1;
        if (gap_q == 3'd1) begin
          state_d = ST_IDLE;
        end
      end
      default: begin
        gnt_d   = '0;
        state_d = ST_IDLE;
      end
    endcase
  end

  // State and output registers; reset clears the grant immediately.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= ST_IDLE;
      gnt_q     <= '0;
      owner_q   <= '0;
      ptr_q     <= '0;
      gap_q     <= '0;
`ifdef MUTEX_HOLD_TIMEOUT_EN
      hold_q    <= '0;
      mask_q    <= '0;
      timeout_q <= 1'b0;
`endif
    end else begin
      state_q   <= state_d;
      gnt_q     <= gnt_d;
      owner_q   <= owner_d;
      ptr_q     <= ptr_d;
      gap_q     <= gap_d;
`ifdef MUTEX_HOLD_TIMEOUT_EN
      hold_q    <= hold_d;
      mask_q    <= mask_d;
      timeout_q <= timeout_d;
`endif
    end
  end

  assign gnt   = gnt_q;
  assign busy  = |gnt_q;
  assign owner = owner_q;

endmodule
`default_nettype wire

// File: tb/tb_mutex_rr_arb.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module   : tb_mutex_rr_arb                                               |
// | Purpose  : scoreboard bench for mutex_rr_arb; a cycle model predicts the |
// |            outputs after each edge, a monitor compares on the falling    |
// |            edge.                                                         |
// | Revision : 1.0  initial release                                          |
// +--------------------------------------------------------------------------+
module tb_mutex_rr_arb;
  localparam int N        = 4;
  localparam int OWN_W    = 2;
  localparam int GAP_CYC  = 1;
  localparam int HOLD_W   = 8;
  localparam int MAX_HOLD = 10;

  logic             clk   = 1'b0;
  logic             rst_n = 1'b0;
  logic [N-1:0]     req   = '0;
  logic [N-1:0]     gnt;
  logic             busy;
  logic [OWN_W-1:0] owner;
  logic             timeout;

  always #5 clk = ~clk;

  mutex_rr_arb #(
    .N(N), .OWN_W(OWN_W), .GAP_CYC(GAP_CYC), .HOLD_W(HOLD_W), .MAX_HOLD(MAX_HOLD)
  ) dut (
    .clk(clk), .rst_n(rst_n), .req(req),
    .gnt(gnt), .busy(busy), .owner(owner), .timeout(timeout)
  );

  typedef struct packed {
    logic [N-1:0]     gnt;
    logic             busy;
    logic [OWN_W-1:0] owner;
    logic             timeout;
  } exp_t;

  exp_t sb[$];
  exp_t mon_e;
  int   vectors     = 0;
  int   miscompares = 0;

  // Reference model: who owns the resource, where the rotation resumes,
  // and the earliest edge index at which a new grant may be issued.
  int           m_cur     = -1;
  int           m_last    = 0;
  int           m_ptr     = 0;
  int           m_edge    = 0;
  int           m_next_ok = 0;
  int           m_gedge   = 0;
  logic [N-1:0] m_mask    = '0;

  task automatic model_reset();
    m_cur = -1; m_last = 0; m_ptr = 0; m_edge = 0; m_next_ok = 0; m_gedge = 0;
    m_mask = '0;
  endtask

  task automatic model_step(input logic [N-1:0] r);
    exp_t         e;
    logic [N-1:0] elig;
    logic [N-1:0] one;
    logic         to;
    logic         found;
    int           j;
    one   = 1;
    to    = 1'b0;
    found = 1'b0;
    elig  = r & ~m_mask;
    m_mask = m_mask & r;
    if (m_cur >= 0) begin
      if (!r[m_cur]) begin
        m_ptr     = (m_cur + 1) % N;
        m_cur     = -1;
        m_next_ok = m_edge + GAP_CYC + 1;
      end
`ifdef MUTEX_HOLD_TIMEOUT_EN
      else if (m_edge - m_gedge >= MAX_HOLD) begin
        m_mask[m_cur] = 1'b1;
        m_ptr     = (m_cur + 1) % N;
        m_cur     = -1;
        m_next_ok = m_edge + GAP_CYC + 1;
        to        = 1'b1;
      end
`endif
    end else if (m_edge >= m_next_ok && elig != '0) begin
      for (int k = 0; k < N; k++) begin
        j = (m_ptr + k) % N;
        if (!found && elig[j]) begin
          found = 1'b1;
          m_cur = j;
        end
      end
      m_last  = m_cur;
      m_gedge = m_edge;
    end
    e.gnt     = (m_cur >= 0) ? (one << m_cur) : '0;
    e.busy    = (m_cur >= 0);
    e.owner   = OWN_W'(m_last);
    e.timeout = to;
    sb.push_back(e);
    m_edge++;
  endtask

  // Predict the post-edge outputs from the request sampled at this edge.
  always @(posedge clk) begin
    if (!rst_n) model_reset();
    else        model_step(req);
  end

  // Compare the DUT against the oldest prediction, away from the active edge.
  always @(negedge clk) begin
    if (rst_n && sb.size() > 0) begin
      mon_e = sb.pop_front();
      vectors++;
      if ({gnt, busy, owner, timeout} !== mon_e) begin
        miscompares++;
        $display("FAIL cycle t=%0t: got gnt=%b busy=%b owner=%0d timeout=%b, want gnt=%b busy=%b owner=%0d timeout=%b",
                 $time, gnt, busy, owner, timeout, mon_e.gnt, mon_e.busy, mon_e.owner, mon_e.timeout);
      end
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic check_reset_state(input string name);
    vectors++;
    if ({gnt, busy, owner, timeout} !== '0) begin
      miscompares++;
      $display("FAIL %s: got gnt=%b busy=%b owner=%0d timeout=%b, want all zero",
               name, gnt, busy, owner, timeout);
    end
  endtask

  // Assert reset asynchronously just after an edge, check outputs cleared.
  task automatic do_reset(input string name);
    @(posedge clk);
    #1;
    rst_n = 1'b0;
    #1;
    sb.delete();
    check_reset_state(name);
    model_reset();
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  task automatic wait_grant(input int idx);
    int n;
    n = 0;
    while (m_cur != idx && n < 40) begin
      step();
      n++;
    end
    if (m_cur != idx) begin
      vectors++;
      miscompares++;
      $display("FAIL wait_grant: master %0d not granted within 40 cycles, model owner %0d", idx, m_cur);
    end
  endtask

  task automatic run(input int cycles);
    for (int c = 0; c < cycles; c++) step();
  endtask

  initial begin
    logic [N-1:0] r;

    // Power-on reset.
    #2;
    check_reset_state("power_on_reset");
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;

    // Single requester: grant, release, gap.
    step();
    req = 4'b0100;
    wait_grant(2);
    run(2);
    req = 4'b0000;
    run(6);

    // All requesting, each owner releasing after three grant cycles.
    req = 4'b1111;
    for (int c = 0; c < 40; c++) begin
      step();
      if (m_cur >= 0 && m_edge - m_gedge >= 3) req[m_cur] = 1'b0;
      else req = 4'b1111;
    end
    req = 4'b0000;
    run(6);

    // No preemption: req[3] arrives while master 1 owns the resource.
    req = 4'b0010;
    wait_grant(1);
    req = 4'b1010;
    run(5);
    req = 4'b1000;
    run(6);
    req = 4'b0000;
    run(4);

    // Wrap-around: move the pointer to 3, then contend 0 and 3.
    req = 4'b0100;
    wait_grant(2);
    req = 4'b0000;
    run(4);
    req = 4'b1001;
    wait_grant(3);
    run(2);
    req = 4'b0001;
    step();
    req = 4'b1001;
    run(6);
    req = 4'b0000;
    run(4);

    // Reset while master 1 holds the grant.
    req = 4'b0010;
    wait_grant(1);
    run(1);
    do_reset("reset_mid_grant");
    req = 4'b0011;
    run(6);
    req = 4'b0000;
    run(4);

    // Long hold by master 0, then release and re-request.
    req = 4'b0001;
    run(MAX_HOLD + 10);
    req = 4'b0000;
    step();
    req = 4'b0001;
    run(6);
    req = 4'b0000;
    run(4);

    // Randomized traffic with legal withdrawals and one mid-run reset.
    for (int c = 0; c < 3000; c++) begin
      if (c == 1500) do_reset("reset_random");
      step();
      r = req;
      for (int i = 0; i < N; i++) begin
        if (i == m_cur) begin
          if ($urandom_range(4) == 0) r[i] = 1'b0;
        end else if ($urandom_range(3) == 0) begin
          r[i] = ~r[i];
        end
      end
      req = r;
    end
    req = 4'b0000;
    run(5);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

  // Absolute time bound so the run always ends.
  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached, got no finish, want finish");
    $fatal(1);
  end

endmodule
`default_nettype wire
